// File: rtl/ram_burst.sv
// Word RAM with command-stream writes and a handshaked single-word read port.
// Address registers post-increment (optional) and wrap at MEM_DEPTH.
module ram_burst #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [WORD_SIZE+1:0] din,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE  = ADDR_SIZE'(1);

  state_t state, state_nx;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [ADDR_SIZE-1:0] rd_base, rd_nx, pay_a;
  logic [1:0]           op;
  logic [WORD_SIZE-1:0] pay;
  logic [31:0]          pay_w;
  logic                 in_range;
  logic                 ld_wr, wr_en, ld_rd, rd_req;
  logic                 fetch, accept, err_nx;

  function automatic logic [ADDR_SIZE-1:0] inc(
    input logic [ADDR_SIZE-1:0] a
  );
    return (a == LAST) ? '0 : a + ONE;
  endfunction

  assign op       = din[WORD_SIZE+1:WORD_SIZE];
  assign pay      = din[WORD_SIZE-1:0];
  assign pay_w    = 32'(pay);
  assign in_range = pay_w < 32'(MEM_DEPTH);
  assign pay_a    = pay_w[ADDR_SIZE-1:0];

  always_comb begin
    ld_wr  = 1'b0;
    wr_en  = 1'b0;
    ld_rd  = 1'b0;
    rd_req = 1'b0;
    if (rx_valid) begin
      unique case (op)
        2'b00: ld_wr  = 1'b1;
        2'b01: wr_en  = 1'b1;
        2'b10: ld_rd  = 1'b1;
        2'b11: rd_req = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rd_req) state_nx = FETCH;
      FETCH:   state_nx = HOLD;
      HOLD:    if (tx_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    fetch  = (state == FETCH);
    accept = (state == HOLD) && tx_ready;
  end

  assign err_nx = (rd_req && busy) ||
                  ((ld_wr || ld_rd) && !in_range);

  // A reload during the read takes effect first, then acceptance bumps it.
  assign rd_base = (ld_rd && in_range) ? pay_a : rd_addr;
  assign rd_nx   = (accept && AUTO_INC != 0) ? inc(rd_base) : rd_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
      dout     <= '0;
      err      <= 1'b0;
    end else begin
      err     <= err_nx;
      rd_addr <= rd_nx;
      if (ld_wr && in_range)
        wr_addr <= pay_a;
      else if (wr_en && AUTO_INC != 0)
        wr_addr <= inc(wr_addr);
      if (fetch) begin
        dout     <= mem[rd_addr];
        tx_valid <= 1'b1;
      end else if (accept) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Unreset storage; a same-edge write leaves the fetch with old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pay;
  end

endmodule
